// File: rtl/pll_reconfig_ctrl.sv
// Avalon-MM sequencer that reprograms a Cyclone V reconfigurable PLL and waits for a filtered re-lock.
// Optional fractional K write is enabled by defining PLL_RECONFIG_FRAC_EN.
module pll_reconfig_ctrl #(
  parameter int NUM_C       = 1,
  parameter int LOCK_FILTER = 16,
  parameter int UNLOCK_WAIT = 256,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic [17:0]          i_cfg_n,
  input  logic [17:0]          i_cfg_m,
  input  logic [18*NUM_C-1:0]  i_cfg_c,
  input  logic [31:0]          i_cfg_k,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  input  logic                 i_pll_locked,
  output logic [5:0]           o_mgmt_address,
  output logic                 o_mgmt_write,
  output logic [31:0]          o_mgmt_writedata,
  input  logic                 i_mgmt_waitrequest
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_MODE, ST_WR_N, ST_WR_M, ST_WR_C, ST_WR_K, ST_WR_START,
    ST_WAIT_UNLOCK, ST_WAIT_LOCK
  } state_t;

  localparam logic [15:0] LF      = 16'(LOCK_FILTER);
  localparam logic [15:0] UW_LAST = 16'(UNLOCK_WAIT - 1);
  // Compare against TIMEOUT_CYC-1 so the full 2^24 range fits the 24-bit counter.
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYC - 1);
  localparam logic [4:0]  C_LAST  = 5'(NUM_C - 1);

  state_t                  r_state;
  logic [17:0]             r_cfg_n, r_cfg_m;
  logic [NUM_C-1:0][17:0]  r_cfg_c;
  logic [4:0]              r_cidx;
  logic [15:0]             r_ucnt;
  logic [15:0]             r_filt;
  logic [23:0]             r_tcnt;

  logic [4:0]              w_cidx_nxt;
  logic [17:0]             w_c_sel;
  logic [15:0]             w_filt_nxt;
  logic [23:0]             w_tcnt_nxt;

`ifdef PLL_RECONFIG_FRAC_EN
  logic [31:0]             r_cfg_k;
`else
  logic                    w_unused_k;
  assign w_unused_k = ^i_cfg_k;
`endif

  assign w_cidx_nxt = r_cidx + 5'd1;
  assign w_filt_nxt = !i_pll_locked     ? 16'd0 :
                      (r_filt == 16'hFFFF) ? r_filt : r_filt + 16'd1;
  assign w_tcnt_nxt = (r_tcnt == 24'hFFFFFF) ? r_tcnt : r_tcnt + 24'd1;

  always_comb begin
    w_c_sel = r_cfg_c[0];
    for (int i = 0; i < NUM_C; i++)
      if (5'(i) == w_cidx_nxt) w_c_sel = r_cfg_c[i];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_err            <= 1'b0;
      o_mgmt_write     <= 1'b0;
      o_mgmt_address   <= 6'd0;
      o_mgmt_writedata <= 32'd0;
      r_cfg_n          <= '0;
      r_cfg_m          <= '0;
      r_cfg_c          <= '0;
      r_cidx           <= '0;
      r_ucnt           <= '0;
      r_filt           <= '0;
      r_tcnt           <= '0;
`ifdef PLL_RECONFIG_FRAC_EN
      r_cfg_k          <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_cfg_n          <= i_cfg_n;
            r_cfg_m          <= i_cfg_m;
            r_cfg_c          <= i_cfg_c;
`ifdef PLL_RECONFIG_FRAC_EN
            r_cfg_k          <= i_cfg_k;
`endif
            o_busy           <= 1'b1;
            o_mgmt_write     <= 1'b1;
            o_mgmt_address   <= 6'h00;
            o_mgmt_writedata <= 32'd0;
            r_state          <= ST_WR_MODE;
          end
        end
        ST_WR_MODE: if (!i_mgmt_waitrequest) begin
          o_mgmt_address   <= 6'h03;
          o_mgmt_writedata <= {14'd0, r_cfg_n};
          r_state          <= ST_WR_N;
        end
        ST_WR_N: if (!i_mgmt_waitrequest) begin
          o_mgmt_address   <= 6'h04;
          o_mgmt_writedata <= {14'd0, r_cfg_m};
          r_state          <= ST_WR_M;
        end
        ST_WR_M: if (!i_mgmt_waitrequest) begin
          r_cidx           <= 5'd0;
          o_mgmt_address   <= 6'h05;
          o_mgmt_writedata <= {9'd0, 5'd0, r_cfg_c[0]};
          r_state          <= ST_WR_C;
        end
        ST_WR_C: if (!i_mgmt_waitrequest) begin
          if (r_cidx == C_LAST) begin
`ifdef PLL_RECONFIG_FRAC_EN
            o_mgmt_address   <= 6'h07;
            o_mgmt_writedata <= r_cfg_k;
            r_state          <= ST_WR_K;
`else
            o_mgmt_address   <= 6'h02;
            o_mgmt_writedata <= 32'd1;
            r_state          <= ST_WR_START;
`endif
          end else begin
            r_cidx           <= w_cidx_nxt;
            o_mgmt_writedata <= {9'd0, w_cidx_nxt, w_c_sel};
          end
        end
        ST_WR_K: if (!i_mgmt_waitrequest) begin
          o_mgmt_address   <= 6'h02;
          o_mgmt_writedata <= 32'd1;
          r_state          <= ST_WR_START;
        end
        ST_WR_START: if (!i_mgmt_waitrequest) begin
          o_mgmt_write     <= 1'b0;
          o_mgmt_address   <= 6'h00;
          o_mgmt_writedata <= 32'd0;
          r_ucnt           <= 16'd0;
          r_state          <= ST_WAIT_UNLOCK;
        end
        ST_WAIT_UNLOCK: begin
          if (!i_pll_locked || r_ucnt == UW_LAST) begin
            r_filt  <= 16'd0;
            r_tcnt  <= 24'd0;
            r_state <= ST_WAIT_LOCK;
          end else begin
            r_ucnt  <= r_ucnt + 16'd1;
          end
        end
        ST_WAIT_LOCK: begin
          r_filt <= w_filt_nxt;
          r_tcnt <= w_tcnt_nxt;
          // Filter completion takes priority over a simultaneous timeout.
          if (w_filt_nxt == LF) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_tcnt == TO_LAST) begin
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: write order, stall, lock filter, timeout, ignored req, reset abort.
module tb_pll_reconfig_ctrl;
  localparam int NUM_C = 3;
`ifdef PLL_RECONFIG_FRAC_EN
  localparam int NWR = 8;
`else
  localparam int NWR = 7;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req = 1'b0;
  logic [17:0]        cfg_n = '0, cfg_m = '0;
  logic [18*NUM_C-1:0] cfg_c = '0;
  logic [31:0]        cfg_k = '0;
  logic               busy, done, err;
  logic               locked = 1'b1;
  logic [5:0]         addr;
  logic               wr;
  logic [31:0]        wdata;
  logic               waitreq = 1'b0;

  pll_reconfig_ctrl #(.NUM_C(NUM_C), .LOCK_FILTER(16), .UNLOCK_WAIT(8), .TIMEOUT_CYC(100)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_cfg_n(cfg_n), .i_cfg_m(cfg_m),
    .i_cfg_c(cfg_c), .i_cfg_k(cfg_k), .o_busy(busy), .o_done(done), .o_err(err),
    .i_pll_locked(locked), .o_mgmt_address(addr), .o_mgmt_write(wr),
    .o_mgmt_writedata(wdata), .i_mgmt_waitrequest(waitreq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [5:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [5:0]  ea[8];
  logic [31:0] ed[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every completed write
  always @(negedge clk)
    if (wr && !waitreq) begin
      wa.push_back(addr); wd.push_back(wdata); wc.push_back(cyc);
    end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_exp(input logic [17:0] n, m, c0, c1, c2, input logic [31:0] k);
    int j;
    ea[0] = 6'h00; ed[0] = 32'd0;
    ea[1] = 6'h03; ed[1] = {14'd0, n};
    ea[2] = 6'h04; ed[2] = {14'd0, m};
    ea[3] = 6'h05; ed[3] = {9'd0, 5'd0, c0};
    ea[4] = 6'h05; ed[4] = {9'd0, 5'd1, c1};
    ea[5] = 6'h05; ed[5] = {9'd0, 5'd2, c2};
    j = 6;
`ifdef PLL_RECONFIG_FRAC_EN
    ea[j] = 6'h07; ed[j] = k; j++;
`else
    if (k == 32'hFFFF_FFFF) j = 6;
`endif
    ea[j] = 6'h02; ed[j] = 32'd1;
  endtask

  task automatic chk_writes(input string tag);
    for (int i = 0; i < NWR; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(ea[i]));
      chk($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
    end
  endtask

  task automatic wait_wr(input string tag);
    int k = 0;
    while (wa.size() < NWR && k < 100) begin tick(); k++; end
    chk(tag, 32'(wa.size()), 32'(NWR));
  endtask

  initial begin
    int n;
    logic bad;
    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_write", 32'(wr), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_data", wdata, 0);
    rst = 1'b0;
    tick();

    // Nominal sequence, then lock glitch before the clean lock
    cfg_n = 18'h10101; cfg_m = 18'h00909;
    cfg_c = {18'h00303, 18'h00707, 18'h00505}; cfg_k = 32'h1234_5678;
    set_exp(18'h10101, 18'h00909, 18'h00505, 18'h00707, 18'h00303, 32'h1234_5678);
    req = 1'b1; tick(); req = 1'b0;
    chk("accept_busy", 32'(busy), 1);
    chk("accept_first_addr", 32'(addr), 0);
    wait_wr("nom_count");
    chk_writes("nom");
    for (int i = 1; i < NWR; i++)
      chk($sformatf("nom_spacing%0d", i), 32'(wc[i] - wc[i-1]), 1);
    locked = 1'b0; repeat (3) tick();
    locked = 1'b1; repeat (10) tick();
    locked = 1'b0; tick();
    locked = 1'b1;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    chk("lock_filter_latency", 32'(n), 16);
    chk("lock_busy_fall", 32'(busy), 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);

    // Waitrequest stall on WR_M, late cfg change, req during WR_C
    wa.delete(); wd.delete(); wc.delete();
    cfg_n = 18'h2ABCD; cfg_m = 18'h00909;
    cfg_c = {18'h12345, 18'h00000, 18'h3FFFF}; cfg_k = 32'hDEAD_BEEF;
    set_exp(18'h2ABCD, 18'h00909, 18'h3FFFF, 18'h00000, 18'h12345, 32'hDEAD_BEEF);
    req = 1'b1; tick(); req = 1'b0;
    cfg_m = 18'h3FFFF; cfg_n = 18'h00000;
    tick(); tick();
    chk("stall_at_m", 32'(addr), 32'h04);
    waitreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_addr%0d", i), 32'(addr), 32'h04);
      chk($sformatf("stall_data%0d", i), wdata, 32'h0000_0909);
    end
    waitreq = 1'b0;
    chk("stall_hold_wr", 32'(wr), 1);
    tick();
    chk("stall_to_c", 32'(addr), 32'h05);
    req = 1'b1; tick(); req = 1'b0;
    wait_wr("stall_count");
    chk_writes("stall");
    n = 0;
    while (!done && n < 60) begin tick(); n++; end
    chk("stall_done", 32'(done), 1);
    chk("stall_busy_fall", 32'(busy), 0);
    repeat (3) tick();
    chk("ignored_req_busy", 32'(busy), 0);
    chk("ignored_req_writes", 32'(wa.size()), 32'(NWR));

    // Timeout with lock held low
    wa.delete(); wd.delete(); wc.delete();
    locked = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    n = 0;
    while (!(wr && addr == 6'h02) && n < 50) begin tick(); n++; end
    chk("to_start_seen", 32'(addr), 32'h02);
    n = 0; bad = 1'b0;
    while (!err && n < 200) begin tick(); n++; if (done) bad = 1'b1; end
    chk("timeout_latency", 32'(n), 102);
    chk("timeout_no_done", 32'(bad), 0);
    chk("timeout_busy_fall", 32'(busy), 0);
    tick();
    chk("err_one_cycle", 32'(err), 0);
    locked = 1'b1;
    wa.delete(); wd.delete(); wc.delete();
    req = 1'b1; tick(); req = 1'b0;
    chk("reaccept_busy", 32'(busy), 1);
    chk("reaccept_write", 32'(wr), 1);

    // Reset while in WAIT_LOCK
    wait_wr("abort_count");
    locked = 1'b0; repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_write", 32'(wr), 0);
    chk("abort_addr", 32'(addr), 0);
    chk("abort_data", wdata, 0);
    locked = 1'b1; bad = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); if (done || err || busy) bad = 1'b1; end
    chk("abort_quiet", 32'(bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
